// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide sequencer.
// The master is the pipeline side, and the slave is the unit itself.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mf_req;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] mt_data;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, src_a, src_b, mf_req, mthi_we, mtlo_we, mt_data, flush,
        input  hi, lo, busy, stall_req, done, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, mf_req, mthi_we, mtlo_we, mt_data, flush,
        output hi, lo, busy, stall_req, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// It works on operand magnitudes and applies the sign correction in the FIX cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = WIDTH
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [1:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;

    logic               accept, is_div, div_zero, fix_ok, signed_in, busy_w;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;

    assign accept   = (state_q == IDLE) && bus.start && !bus.flush;
    assign is_div   = op_q[1];
    assign div_zero = is_div && (opb_q == '0);
    assign fix_ok   = (state_q == FIX) && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (bus.flush) state_d = IDLE;
                     else if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        signed_in = !bus.op[0];
        a_mag     = (signed_in && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
        b_mag     = (signed_in && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
        // The multiplier shifts out of acc_lo while product bits shift in from acc_hi.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = div_shift >= {1'b0, opb_q};
        prod_mag  = {acc_hi_q, acc_lo_q};
        prod_fix  = (!op_q[0] && (neg_a_q ^ neg_b_q)) ? -prod_mag : prod_mag;
        quo_fix   = (!op_q[0] && (neg_a_q ^ neg_b_q)) ? -acc_lo_q : acc_lo_q;
        rem_fix   = (!op_q[0] && neg_a_q) ? -acc_hi_q : acc_hi_q;

        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;

        case (state_q)
            IDLE: begin
                // An MT write lands even if a flush or a new op arrives in the same cycle.
                if (bus.mthi_we) hi_d = bus.mt_data;
                if (bus.mtlo_we) lo_d = bus.mt_data;
                if (accept) begin
                    op_d     = bus.op;
                    neg_a_d  = signed_in && bus.src_a[WIDTH-1];
                    neg_b_d  = signed_in && bus.src_b[WIDTH-1];
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                    opb_d    = b_mag;
                    cnt_d    = CW'(ITER - 1);
                end
            end
            CALC: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                if (is_div) begin
                    acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                if (fix_ok && !div_zero) begin
                    if (is_div) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_w          = (state_q != IDLE);
        bus.busy        = busy_w;
        bus.stall_req   = busy_w && (bus.start || bus.mf_req || bus.mthi_we || bus.mtlo_we);
        bus.done        = fix_ok;
        bus.div_by_zero = fix_ok && div_zero;
        bus.hi          = hi_q;
        bus.lo          = lo_q;
    end
endmodule
